// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the RV32I core, with flush, hold and load-use bubble insertion.
// Define LOAD_USE_DETECT_EN to build the load-use hazard detector; otherwise software must fill load delay slots.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_load,
  input  logic             id_store,
  input  logic             id_branch,
  input  logic             id_reg_write,
  input  logic             id_mem_en,
  input  logic             id_operand_a,
  input  logic             id_operand_b,
  input  logic             id_next_sel,
  input  logic [1:0]       id_mem_to_reg,
  input  logic [3:0]       id_alu_control,
  input  logic [2:0]       id_fun3,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_flush,
  input  logic             ex_hold,
  output logic             ex_valid,
  output logic             ex_load,
  output logic             ex_store,
  output logic             ex_branch,
  output logic             ex_reg_write,
  output logic             ex_mem_en,
  output logic             ex_operand_a,
  output logic             ex_operand_b,
  output logic             ex_next_sel,
  output logic [1:0]       ex_mem_to_reg,
  output logic [3:0]       ex_alu_control,
  output logic [2:0]       ex_fun3,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1_addr,
  output logic [4:0]       ex_rs2_addr,
  output logic [4:0]       ex_rd_addr,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Controls are zeroed on kill; data fields simply ride along.
  typedef struct packed {
    logic       load;
    logic       store;
    logic       branch;
    logic       reg_write;
    logic       mem_en;
    logic       operand_a;
    logic       operand_b;
    logic       next_sel;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    logic [2:0]      fun3;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
  } data_t;

  ctrl_t            id_ctrl, ex_ctrl;
  data_t            id_data, ex_data;
  logic             ex_vld;
  logic [CNT_W-1:0] cnt;
  logic             lu;

  assign id_ctrl = {id_load, id_store, id_branch, id_reg_write, id_mem_en,
                    id_operand_a, id_operand_b, id_next_sel, id_mem_to_reg, id_alu_control};
  assign id_data = {id_fun3, id_pc, id_rs1_data, id_rs2_data, id_imm,
                    id_rs1_addr, id_rs2_addr, id_rd_addr};

`ifdef LOAD_USE_DETECT_EN
  logic rs1_hit, rs2_hit;
  assign rs1_hit = id_rs1_used && (id_rs1_addr == ex_data.rd_addr);
  assign rs2_hit = id_rs2_used && (id_rs2_addr == ex_data.rd_addr);
  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign lu = ex_vld && ex_ctrl.load && (ex_data.rd_addr != 5'd0) && id_valid
              && (rs1_hit || rs2_hit);
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{id_rs1_used, id_rs2_used};
  assign lu = 1'b0;
`endif

  assign stall_o = !ex_flush && (lu || ex_hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_vld  <= 1'b0;
      ex_ctrl <= '0;
      ex_data <= '0;
      cnt     <= '0;
    end else if (ex_flush) begin
      ex_vld  <= 1'b0;
      ex_ctrl <= '0;
    end else if (!ex_hold) begin
      if (lu) begin
        ex_vld  <= 1'b0;
        ex_ctrl <= '0;
        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
      end else begin
        ex_vld  <= id_valid;
        ex_ctrl <= id_valid ? id_ctrl : '0;
        ex_data <= id_data;
      end
    end
  end

  assign ex_valid = ex_vld;
  assign {ex_load, ex_store, ex_branch, ex_reg_write, ex_mem_en,
          ex_operand_a, ex_operand_b, ex_next_sel, ex_mem_to_reg, ex_alu_control} = ex_ctrl;
  assign {ex_fun3, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
          ex_rs1_addr, ex_rs2_addr, ex_rd_addr} = ex_data;
  assign bubble_cnt = cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against an instruction-slot model.
// Expectations follow LOAD_USE_DETECT_EN the same way the design does.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef LOAD_USE_DETECT_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  typedef struct packed {
    logic valid, load, store, branch, reg_write, mem_en, operand_a, operand_b, next_sel;
    logic [1:0]  mem_to_reg;
    logic [3:0]  alu_control;
    logic [2:0]  fun3;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rs1_used, rs2_used;
  } id_t;

  logic clk = 1'b0;
  logic rst, ex_flush, ex_hold;
  id_t  cur;

  logic ex_valid, ex_load, ex_store, ex_branch, ex_reg_write, ex_mem_en;
  logic ex_operand_a, ex_operand_b, ex_next_sel, stall_o;
  logic [1:0] ex_mem_to_reg;
  logic [3:0] ex_alu_control;
  logic [2:0] ex_fun3;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [CNT_W-1:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(cur.valid),
    .id_load(cur.load), .id_store(cur.store), .id_branch(cur.branch),
    .id_reg_write(cur.reg_write), .id_mem_en(cur.mem_en),
    .id_operand_a(cur.operand_a), .id_operand_b(cur.operand_b), .id_next_sel(cur.next_sel),
    .id_mem_to_reg(cur.mem_to_reg), .id_alu_control(cur.alu_control), .id_fun3(cur.fun3),
    .id_pc(cur.pc), .id_rs1_data(cur.rs1_data), .id_rs2_data(cur.rs2_data), .id_imm(cur.imm),
    .id_rs1_addr(cur.rs1_addr), .id_rs2_addr(cur.rs2_addr), .id_rd_addr(cur.rd_addr),
    .id_rs1_used(cur.rs1_used), .id_rs2_used(cur.rs2_used),
    .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_branch(ex_branch),
    .ex_reg_write(ex_reg_write), .ex_mem_en(ex_mem_en), .ex_operand_a(ex_operand_a),
    .ex_operand_b(ex_operand_b), .ex_next_sel(ex_next_sel), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_control(ex_alu_control), .ex_fun3(ex_fun3), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );

  logic [13:0]  act_ctrl;
  logic [145:0] act_data;
  assign act_ctrl = {ex_load, ex_store, ex_branch, ex_reg_write, ex_mem_en, ex_operand_a,
                     ex_operand_b, ex_next_sel, ex_mem_to_reg, ex_alu_control};
  assign act_data = {ex_fun3, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                     ex_rs1_addr, ex_rs2_addr, ex_rd_addr};

  int n_cmp = 0;
  int n_err = 0;

  // Model: the EX slot holds either a real instruction or nothing.
  bit  m_valid;
  id_t m_inst;
  int  m_cnt;

  function automatic logic [13:0] ctrl_of(id_t x);
    return {x.load, x.store, x.branch, x.reg_write, x.mem_en, x.operand_a,
            x.operand_b, x.next_sel, x.mem_to_reg, x.alu_control};
  endfunction

  function automatic logic [145:0] data_of(id_t x);
    return {x.fun3, x.pc, x.rs1_data, x.rs2_data, x.imm, x.rs1_addr, x.rs2_addr, x.rd_addr};
  endfunction

  function automatic logic [13:0] exp_ctrl();
    return m_valid ? ctrl_of(m_inst) : 14'd0;
  endfunction

  function automatic bit model_lu();
    bit reads_rd;
    reads_rd = (cur.rs1_used && cur.rs1_addr == m_inst.rd_addr) ||
               (cur.rs2_used && cur.rs2_addr == m_inst.rd_addr);
    return LU_EN && m_valid && m_inst.load && m_inst.rd_addr != 0 && cur.valid && reads_rd;
  endfunction

  function automatic bit model_stall();
    return !ex_flush && (model_lu() || ex_hold);
  endfunction

  function automatic id_t rand_id();
    id_t x;
    x.valid = 1'($urandom); x.load = 1'($urandom); x.store = 1'($urandom);
    x.branch = 1'($urandom); x.reg_write = 1'($urandom); x.mem_en = 1'($urandom);
    x.operand_a = 1'($urandom); x.operand_b = 1'($urandom); x.next_sel = 1'($urandom);
    x.mem_to_reg = 2'($urandom); x.alu_control = 4'($urandom); x.fun3 = 3'($urandom);
    x.pc = $urandom; x.rs1_data = $urandom; x.rs2_data = $urandom; x.imm = $urandom;
    x.rs1_addr = 5'($urandom_range(0, 3)); x.rs2_addr = 5'($urandom_range(0, 3));
    x.rd_addr = 5'($urandom_range(0, 3));
    x.rs1_used = 1'($urandom); x.rs2_used = 1'($urandom);
    return x;
  endfunction

  function automatic id_t mk(bit v, bit ld, logic [4:0] rd, logic [4:0] rs1, bit u1,
                             logic [4:0] rs2, bit u2);
    id_t x;
    x = rand_id();
    x.valid = v; x.load = ld; x.rd_addr = rd;
    x.rs1_addr = rs1; x.rs1_used = u1; x.rs2_addr = rs2; x.rs2_used = u2;
    return x;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_inst  = '0;
    m_cnt   = 0;
  endfunction

  // Advance model and DUT by one edge; returns at posedge+1.
  task automatic tick();
    bit  lu, f, h;
    id_t c;
    lu = model_lu(); f = ex_flush; h = ex_hold; c = cur;
    @(posedge clk); #1;
    if (f) m_valid = 1'b0;
    else if (!h) begin
      if (lu) begin
        m_valid = 1'b0;
        if (m_cnt < CMAX) m_cnt++;
      end else begin
        m_valid = c.valid;
        m_inst  = c;
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0; cur = '0;
    model_reset();
    #12;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", ex_valid); end
    n_cmp++; if (act_ctrl !== 14'd0) begin n_err++; $display("FAIL reset_ctrl: got %0h expected 0", act_ctrl); end
    n_cmp++; if (act_data !== 146'd0) begin n_err++; $display("FAIL reset_data: got %0h expected 0", act_data); end
    n_cmp++; if (bubble_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", bubble_cnt); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b expected 0", stall_o); end
    release_reset();
  endtask

  task automatic test_capture();
    cur = mk(1, 0, 5'd3, 5'd1, 0, 5'd2, 0);
    cur.alu_control = 4'b0101; cur.rs1_data = 32'h1234;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL cap_stall: got %0b expected 0", stall_o); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL cap_valid: got %0b expected 1", ex_valid); end
    n_cmp++; if (ex_alu_control !== 4'b0101) begin n_err++; $display("FAIL cap_alu: got %0h expected 5", ex_alu_control); end
    n_cmp++; if (ex_rs1_data !== 32'h1234) begin n_err++; $display("FAIL cap_rs1: got %0h expected 1234", ex_rs1_data); end
    n_cmp++; if (act_ctrl !== exp_ctrl()) begin n_err++; $display("FAIL cap_ctrl: got %0h expected %0h", act_ctrl, exp_ctrl()); end
    // Invalid ID slot: controls must come out zero even when asserted at the input.
    cur = mk(0, 1, 5'd2, 5'd1, 1, 5'd1, 1);
    cur.reg_write = 1'b1; cur.mem_en = 1'b1; cur.alu_control = 4'hf;
    tick();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL cap_inv_valid: got %0b expected 0", ex_valid); end
    n_cmp++; if (act_ctrl !== 14'd0) begin n_err++; $display("FAIL cap_inv_ctrl: got %0h expected 0", act_ctrl); end
    n_cmp++; if (ex_rd_addr !== 5'd2) begin n_err++; $display("FAIL cap_inv_rd: got %0d expected 2", ex_rd_addr); end
  endtask

  task automatic test_load_use();
    id_t add;
    cur = mk(1, 1, 5'd5, 5'd2, 1, 5'd0, 0);
    tick();
    add = mk(1, 0, 5'd6, 5'd5, 1, 5'd1, 1);
    cur = add; #1;
    n_cmp++; if (stall_o !== LU_EN) begin n_err++; $display("FAIL lu_stall: got %0b expected %0b", stall_o, LU_EN); end
    tick();
    n_cmp++; if (ex_valid !== !LU_EN) begin n_err++; $display("FAIL lu_bubble: got %0b expected %0b", ex_valid, !LU_EN); end
    n_cmp++; if (bubble_cnt !== 2'(LU_EN)) begin n_err++; $display("FAIL lu_cnt: got %0d expected %0d", bubble_cnt, LU_EN); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_one_cycle: got %0b expected 0", stall_o); end
    tick();
    n_cmp++; if (ex_valid !== 1'b1 || act_data !== data_of(add)) begin
      n_err++; $display("FAIL lu_after: got v=%0b rd=%0d expected v=1 rd=6", ex_valid, ex_rd_addr);
    end
  endtask

  task automatic test_x0_unused();
    cur = mk(1, 1, 5'd0, 5'd1, 0, 5'd1, 0); tick();
    cur = mk(1, 0, 5'd7, 5'd0, 1, 5'd0, 1); #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %0b expected 0", stall_o); end
    tick();
    cur = mk(1, 1, 5'd5, 5'd1, 0, 5'd1, 0); tick();
    cur = mk(1, 0, 5'd5, 5'd5, 0, 5'd5, 0); #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL unused_stall: got %0b expected 0", stall_o); end
    tick();
    cur = mk(1, 1, 5'd5, 5'd1, 0, 5'd1, 0); tick();
    cur = mk(1, 0, 5'd0, 5'd1, 1, 5'd5, 1); cur.store = 1'b1; #1;
    n_cmp++; if (stall_o !== LU_EN) begin n_err++; $display("FAIL store_stall: got %0b expected %0b", stall_o, LU_EN); end
    tick();
    n_cmp++; if (bubble_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL store_cnt: got %0d expected %0d", bubble_cnt, m_cnt); end
    tick();
  endtask

  task automatic test_flush();
    int cnt0;
    cur = mk(1, 1, 5'd5, 5'd1, 0, 5'd1, 0); tick();
    cur = mk(1, 0, 5'd6, 5'd5, 1, 5'd5, 1); cur.reg_write = 1'b1;
    ex_flush = 1'b1; cnt0 = m_cnt; #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %0b expected 0", stall_o); end
    tick();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      n_err++; $display("FAIL flush_kill: got v=%0b rw=%0b expected 0 0", ex_valid, ex_reg_write);
    end
    n_cmp++; if (bubble_cnt !== CNT_W'(cnt0)) begin n_err++; $display("FAIL flush_cnt: got %0d expected %0d", bubble_cnt, cnt0); end
    ex_flush = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    logic [13:0]  sc;
    logic [145:0] sd;
    int cnt0;
    cur = mk(1, 0, 5'd9, 5'd1, 0, 5'd1, 0); cur.reg_write = 1'b1; tick();
    sc = ctrl_of(cur); sd = data_of(cur);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur = rand_id(); #1;
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL hold_stall%0d: got %0b expected 1", i, stall_o); end
      tick();
      n_cmp++; if (ex_valid !== 1'b1 || act_ctrl !== sc || act_data !== sd) begin
        n_err++; $display("FAIL hold_keep%0d: got ctrl %0h expected %0h", i, act_ctrl, sc);
      end
    end
    ex_hold = 1'b0;
    cur = mk(1, 1, 5'd5, 5'd1, 0, 5'd1, 0); tick();
    cur = mk(1, 0, 5'd6, 5'd5, 1, 5'd2, 0); ex_hold = 1'b1; cnt0 = m_cnt; #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL hold_lu_stall: got %0b expected 1", stall_o); end
    tick();
    n_cmp++; if (bubble_cnt !== CNT_W'(cnt0) || ex_load !== 1'b1) begin
      n_err++; $display("FAIL hold_lu_keep: got cnt=%0d ld=%0b expected %0d 1", bubble_cnt, ex_load, cnt0);
    end
    ex_hold = 1'b0; #1;
    n_cmp++; if (stall_o !== LU_EN) begin n_err++; $display("FAIL hold_release: got %0b expected %0b", stall_o, LU_EN); end
    tick();
    cur = mk(1, 0, 5'd1, 5'd2, 0, 5'd2, 0); ex_hold = 1'b1; ex_flush = 1'b1; tick();
    n_cmp++; if (ex_valid !== 1'b0 || act_ctrl !== 14'd0) begin
      n_err++; $display("FAIL flush_over_hold: got v=%0b ctrl=%0h expected 0 0", ex_valid, act_ctrl);
    end
    ex_hold = 1'b0; ex_flush = 1'b0; tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      cur = mk(1, 1, 5'd5, 5'd1, 0, 5'd1, 0); tick();
      cur = mk(1, 0, 5'd6, 5'd5, 1, 5'd1, 0); tick();
      n_cmp++; if (bubble_cnt !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL sat_step%0d: got %0d expected %0d", i, bubble_cnt, m_cnt); end
    end
    n_cmp++; if (bubble_cnt !== (LU_EN ? 2'd3 : 2'd0)) begin
      n_err++; $display("FAIL sat_final: got %0d expected %0d", bubble_cnt, LU_EN ? 3 : 0);
    end
  endtask

  task automatic test_reset_mid();
    cur = mk(1, 0, 5'd4, 5'd1, 0, 5'd1, 0); cur.reg_write = 1'b1; tick();
    ex_hold = 1'b1; tick();
    #2; rst = 1'b1; ex_hold = 1'b0; model_reset(); #1;
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || act_data !== 146'd0 || bubble_cnt !== 2'd0) begin
      n_err++; $display("FAIL rst_mid_hold: got v=%0b rw=%0b cnt=%0d expected 0 0 0", ex_valid, ex_reg_write, bubble_cnt);
    end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall: got %0b expected 0", stall_o); end
    release_reset();
    cur = mk(1, 1, 5'd5, 5'd1, 0, 5'd1, 0); tick();
    cur = mk(1, 0, 5'd6, 5'd5, 1, 5'd1, 0); #2;
    rst = 1'b1; model_reset(); #1;
    n_cmp++; if (stall_o !== 1'b0 || ex_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_bubble: got stall=%0b v=%0b expected 0 0", stall_o, ex_valid);
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cur = rand_id();
      ex_flush = ($urandom_range(0, 9) == 0);
      ex_hold  = ($urandom_range(0, 7) == 0);
      #1;
      n_cmp++; if (stall_o !== model_stall()) begin
        n_err++; $display("FAIL rnd_stall%0d: got %0b expected %0b", i, stall_o, model_stall());
      end
      tick();
      n_cmp++; if (ex_valid !== m_valid || act_ctrl !== exp_ctrl() || bubble_cnt !== CNT_W'(m_cnt)) begin
        n_err++; $display("FAIL rnd_out%0d: got v=%0b ctrl=%0h cnt=%0d expected v=%0b ctrl=%0h cnt=%0d",
                          i, ex_valid, act_ctrl, bubble_cnt, m_valid, exp_ctrl(), m_cnt);
      end
      if (m_valid) begin
        n_cmp++; if (act_data !== data_of(m_inst)) begin
          n_err++; $display("FAIL rnd_data%0d: got %0h expected %0h", i, act_data, data_of(m_inst));
        end
      end
    end
    ex_flush = 1'b0; ex_hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_x0_unused();
    test_flush();
    test_hold();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I core. It captures the control decoder's outputs together with operand data from the register file and immediate generator, and presents them registered to the execute stage. It also detects load-use hazards, inserting one bubble and stalling IF/ID. Flush from a taken branch or jump, and a hold from downstream, are handled here.

## Interface
- XLEN, 32, data/PC width
- CNT_W, 16, width of bubble counter
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_load, id_store, id_branch, id_reg_write, id_mem_en, id_operand_a, id_operand_b, id_next_sel  in  1 each  decoder controls
- id_mem_to_reg  in  2  writeback select
- id_alu_control  in  4  ALU op
- id_fun3  in  3  funct3 for branch/memory size
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register indices
- id_rs1_used, id_rs2_used  in  1 each  instruction reads rs1/rs2
- ex_flush  in  1  taken branch/jump resolved in EX; kill younger instruction
- ex_hold  in  1  downstream busy; freeze this register
- ex_valid  out  1  EX entry is real
- ex_* (one per id_* above except id_valid, id_rs*_used)  out  same width  registered copies
- stall_o  out  1  freeze PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  saturating count of inserted load-use bubbles

## Operation
- Load-use hazard `lu` requires all of:
  - ex_valid & ex_load
  - ex_rd_addr != 0
  - id_valid
  - (id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)
- Per-edge action, in priority order:
  1. ex_flush: ex_valid<=0 and all control outputs <=0 (reg_write, mem_en, store, load, branch, next_sel, operand_a/b, mem_to_reg, alu_control). Data fields are don't-care; they may be held.
  2. ex_hold: all registers keep their value.
  3. lu: insert a bubble. ex_valid<=0 and controls <=0, as in a flush. bubble_cnt increments, saturating at all-ones.
  4. Otherwise capture: ex_valid<=id_valid. All fields <=id_*. If id_valid=0, controls are zeroed regardless of the id_* control inputs.
- stall_o = lu | ex_hold, gated off when ex_flush=1.
- A bubble clears ex_load, so lu self-clears the next cycle. Each load-use costs exactly one stall cycle.
- Register x0 never triggers a hazard.
- A store whose rs2 matches the load's rd still stalls; there is no MEM-stage forwarding exception.

## Timing
- Reset (asynchronous assert, synchronous deassert at the system level):
  - ex_valid=0, all ex_* =0, bubble_cnt=0.
  - stall_o evaluates to 0 because ex_valid=0.
- Capture latency is 1 cycle: the id_* value at edge N appears on ex_* after edge N.
- stall_o is combinational from the current EX registers and the id_* inputs. It is valid in the same cycle, before the edge.
- Simultaneous events:
  - ex_flush + ex_hold: flush wins.
  - ex_flush + lu: flush wins, stall_o=0, no bubble count.
  - ex_hold + lu: hold wins, stall_o=1, no count; lu re-evaluates after the hold releases.
- Reset mid-hold or mid-bubble clears everything immediately; no residual stall.

## Configuration
- LOAD_USE_DETECT_EN:
  - Defined: hazard logic as above.
  - Undefined: lu is constant 0, stall_o=ex_hold, bubble_cnt is held at 0, and the compiler must schedule load delay slots.

## Test plan
- Reset mid-operation: assert rst while ex_valid=1, ex_reg_write=1 -> all outputs 0 asynchronously, before the next clk edge.
- Plain capture: id_valid=1, id_alu_control=4'b0101, id_rs1_data=32'h1234 -> next cycle ex_valid=1, ex_alu_control=4'b0101, ex_rs1_data=32'h1234, stall_o=0.
- Load-use:
  - Stimulus: lw x5 in EX; ID holds add x6,x5,x1 with rs1_used=1.
  - Required: stall_o=1 for exactly one cycle, next ex_valid=0, bubble_cnt 0->1. The add captures on the following edge.
- x0 / unused operand: lw x0 then use of x0 -> stall_o=0. lw x5 then lui x5 with rs*_used=0 -> stall_o=0.
- Flush priority: ex_flush=1 with a load-use condition present -> stall_o=0, ex_valid=0, ex_reg_write=0, bubble_cnt unchanged.
- Hold and saturation: ex_hold=1 for 3 cycles -> ex_* unchanged, stall_o=1. With CNT_W=2, 5 bubbles -> bubble_cnt=3.
